mest_pro_mem_arbiter: RTL and testbench
=======================================

Name:
mest_pro_mem_arbiter

Overview:
- Shares the single MESTPro memory port between two requesters.
  - Instruction fetch (IF), driven during the FETCH phase.
  - Load/store (LS), driven during the EXECUTE phase.
- Grants one transfer at a time, holds the memory request stable until acknowledged, and returns read data to the owning requester.
- Includes a watchdog so a hung memory cannot freeze the core sequencer.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT, 15, maximum cycles waiting for i_mem_ack before abort (1..255).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_if_req  in  1  fetch request, level.
- i_if_addr  in  ADDR_W  fetch address.
- o_if_gnt  out  1  one-cycle pulse: fetch request accepted.
- o_if_rvalid  out  1  one-cycle pulse: fetch data valid.
- o_if_rdata  out  DATA_W  fetch read data.
- i_ls_req  in  1  load/store request, level.
- i_ls_we  in  1  1 = store, 0 = load.
- i_ls_addr  in  ADDR_W  load/store address.
- i_ls_wdata  in  DATA_W  store data.
- o_ls_gnt  out  1  one-cycle pulse: load/store request accepted.
- o_ls_rvalid  out  1  one-cycle pulse: load data valid or store complete.
- o_ls_rdata  out  DATA_W  load read data.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  DATA_W  memory write data.
- i_mem_ack  in  1  memory completion, one cycle.
- i_mem_rdata  in  DATA_W  memory read data, valid with i_mem_ack.
- o_busy  out  1  a transfer is in flight.
- o_timeout  out  1  sticky watchdog error flag.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset i_reset_n is asynchronous, active-low.
  - Reset forces every output to 0, the state to IDLE and the watchdog counter to 0.
  - Reset mid-transfer drops o_mem_req immediately and abandons the transfer; no rvalid is issued.
- State machine, 2-bit: IDLE, IF_XFER, LS_XFER. Unused encodings return to IDLE.
- IDLE:
  - Requests are sampled every cycle.
  - Only i_ls_req high -> LS_XFER.
  - Only i_if_req high -> IF_XFER.
  - Both high: fixed priority, LS wins.
- On the transition edge into a transfer state:
  - Register the address/we/wdata of the winner onto o_mem_*.
  - Assert o_mem_req.
  - Pulse the winner's gnt for exactly 1 cycle.
  - Clear the watchdog counter.
  - IF transfers force o_mem_we = 0.
- Latency:
  - Request seen in IDLE at cycle N -> gnt and o_mem_req high at N+1.
  - i_mem_ack at cycle M -> rvalid pulse and o_mem_req low at M+1.
  - The arbiter is back in IDLE at M+1, so the next grant is no earlier than M+2 (one bubble minimum).
- While in a transfer state:
  - o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata are held constant.
  - Requester inputs are ignored.
  - o_busy = 1.
- Request handshake:
  - Requesters drop req the cycle after gnt.
  - A req still high when the arbiter returns to IDLE counts as a new request.
- Completion:
  - On i_mem_ack, rdata is captured into the owner's o_*_rdata register. It holds until that owner's next completion.
  - For a store, o_ls_rvalid still pulses and o_ls_rdata is unchanged.
- i_mem_ack while in IDLE is ignored.
- Watchdog:
  - The counter increments each transfer cycle without ack.
  - On reaching TIMEOUT:
    - Drop o_mem_req.
    - Pulse the owner's rvalid with rdata = all ones.
    - Set o_timeout.
    - Return to IDLE.
  - o_timeout clears only on reset.
  - If ack arrives in the same cycle the counter reaches TIMEOUT, ack wins and no timeout is flagged.
- Counter width is $clog2(TIMEOUT+1).

Optional Feature:
- Macro: MEST_PRO_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-owner register (reset = IF) is updated on every grant.
  - When both requests are high in IDLE, the requester that did not win last is granted.
  - A single request is granted as before.
- Undefined: fixed LS-over-IF priority; the last-owner register is not built.

Decomposition:
- Package mest_pro_pkg holds:
  - The state enum (IDLE/IF_XFER/LS_XFER).
  - The requester-id enum (REQ_IF/REQ_LS).
  - Default width constants ADDR_W_DEF = 16 and DATA_W_DEF = 16.
- One natural sub-module: mest_pro_arb_watchdog.
  - Ports: clear, enable, ack; output expire.
  - Encapsulates the counter, the TIMEOUT compare and ack precedence.

Test Plan:
- Single load: i_ls_req=1, i_ls_addr=16'h0040 at cycle 1.
  - Cycle 2: o_ls_gnt=1, o_mem_req=1, o_mem_addr=16'h0040, o_mem_we=0.
  - i_mem_ack=1 with i_mem_rdata=16'hBEEF at cycle 4.
  - Cycle 5: o_ls_rvalid=1, o_ls_rdata=16'hBEEF, o_mem_req=0.
- Contention: i_if_req=1 and i_ls_req=1 at the same cycle, both held.
  - LS is granted first.
  - IF is granted 2 cycles after the LS ack.
  - With MEST_PRO_ARB_ROUND_ROBIN_EN, the first grant after reset goes to LS and the next contention grant goes to IF.
- Store: i_ls_we=1, i_ls_wdata=16'h1234.
  - o_mem_we=1, o_mem_wdata=16'h1234, held stable until ack.
  - o_ls_rvalid pulses one cycle after ack; o_ls_rdata is unchanged.
- Timeout: IF transfer with no ack, TIMEOUT=15.
  - After 15 transfer cycles: o_if_rvalid=1, o_if_rdata=16'hFFFF, o_timeout=1 (sticky), o_mem_req=0.
  - The next request is granted normally.
- Ack on the deadline: i_mem_ack arrives on the 15th transfer cycle.
  - Normal completion, o_timeout stays 0.
- Reset mid-transfer: i_reset_n=0 while o_mem_req=1.
  - All outputs 0 immediately, with no rvalid.
  - After release, an IF request is granted with 1-cycle latency.

Source files
------------

// File: rtl/mest_pro_pkg.sv
// Shared types and default widths for the MESTPro memory arbiter.
package mest_pro_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_XFER = 2'd1,
    LS_XFER = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_t;

endpackage

// File: rtl/mest_pro_arb_watchdog.sv
// Transfer watchdog: counts un-acked transfer cycles and flags expiry on the
// cycle the count reaches TIMEOUT; an ack in that same cycle takes precedence.
module mest_pro_arb_watchdog
  import mest_pro_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic ack,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !ack) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // count_reg holds the number of completed un-acked cycles, so this cycle is the TIMEOUT-th.
  assign expire = enable && !ack && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mest_pro_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter for the single MESTPro memory port.
// Define MEST_PRO_ARB_ROUND_ROBIN_EN to alternate winners under contention.
module mest_pro_mem_arbiter
  import mest_pro_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_timeout
);

  arb_state_t state_reg;
  logic       pick_ls;
  logic       wd_expire;

`ifdef MEST_PRO_ARB_ROUND_ROBIN_EN
  req_id_t last_owner_reg;
  assign pick_ls = i_ls_req && (!i_if_req || (last_owner_reg == REQ_IF));
`else
  assign pick_ls = i_ls_req;
`endif

  assign o_busy = (state_reg != IDLE);

  mest_pro_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (i_reset_n),
    .clear  (state_reg == IDLE),
    .enable (state_reg != IDLE),
    .ack    (i_mem_ack),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg   <= IDLE;
      o_if_gnt    <= 1'b0;
      o_if_rvalid <= 1'b0;
      o_if_rdata  <= '0;
      o_ls_gnt    <= 1'b0;
      o_ls_rvalid <= 1'b0;
      o_ls_rdata  <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_timeout   <= 1'b0;
`ifdef MEST_PRO_ARB_ROUND_ROBIN_EN
      last_owner_reg <= REQ_IF;
`endif
    end else begin
      o_if_gnt    <= 1'b0;
      o_ls_gnt    <= 1'b0;
      o_if_rvalid <= 1'b0;
      o_ls_rvalid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_ls) begin
            state_reg   <= LS_XFER;
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_ls_we;
            o_mem_addr  <= i_ls_addr;
            o_mem_wdata <= i_ls_wdata;
            o_ls_gnt    <= 1'b1;
`ifdef MEST_PRO_ARB_ROUND_ROBIN_EN
            last_owner_reg <= REQ_LS;
`endif
          end else if (i_if_req) begin
            state_reg  <= IF_XFER;
            o_mem_req  <= 1'b1;
            o_mem_we   <= 1'b0;
            o_mem_addr <= i_if_addr;
            o_if_gnt   <= 1'b1;
`ifdef MEST_PRO_ARB_ROUND_ROBIN_EN
            last_owner_reg <= REQ_IF;
`endif
          end
        end
        IF_XFER: begin
          if (i_mem_ack) begin
            state_reg   <= IDLE;
            o_mem_req   <= 1'b0;
            o_if_rvalid <= 1'b1;
            o_if_rdata  <= i_mem_rdata;
          end else if (wd_expire) begin
            state_reg   <= IDLE;
            o_mem_req   <= 1'b0;
            o_if_rvalid <= 1'b1;
            o_if_rdata  <= '1;
            o_timeout   <= 1'b1;
          end
        end
        LS_XFER: begin
          if (i_mem_ack) begin
            state_reg   <= IDLE;
            o_mem_req   <= 1'b0;
            o_ls_rvalid <= 1'b1;
            // Stores complete with an rvalid pulse but leave the load data untouched.
            if (!o_mem_we) begin
              o_ls_rdata <= i_mem_rdata;
            end
          end else if (wd_expire) begin
            state_reg   <= IDLE;
            o_mem_req   <= 1'b0;
            o_ls_rvalid <= 1'b1;
            o_ls_rdata  <= '1;
            o_timeout   <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mest_pro_mem_arbiter.sv
// Self-checking bench: vector table of single transfers plus hand-written
// sequences (idle ack, reset mid-transfer, contention); rvalid data via scoreboard.
module tb_mest_pro_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt;
  logic          o_if_rvalid;
  logic [DW-1:0] o_if_rdata;
  logic          i_ls_req;
  logic          i_ls_we;
  logic [AW-1:0] i_ls_addr;
  logic [DW-1:0] i_ls_wdata;
  logic          o_ls_gnt;
  logic          o_ls_rvalid;
  logic [DW-1:0] o_ls_rdata;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_ack;
  logic [DW-1:0] i_mem_rdata;
  logic          o_busy;
  logic          o_timeout;

  always #5 clk = ~clk;

  mest_pro_mem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .i_reset_n   (i_reset_n),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_rvalid (o_if_rvalid),
    .o_if_rdata  (o_if_rdata),
    .i_ls_req    (i_ls_req),
    .i_ls_we     (i_ls_we),
    .i_ls_addr   (i_ls_addr),
    .i_ls_wdata  (i_ls_wdata),
    .o_ls_gnt    (o_ls_gnt),
    .o_ls_rvalid (o_ls_rvalid),
    .o_ls_rdata  (o_ls_rdata),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  typedef struct {
    logic          is_ls;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;      // extra cycles after gnt before ack; >= TO means never ack
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_to;
  } vec_t;

  typedef struct {
    logic          owner_ls;
    logic [DW-1:0] rdata;
  } exp_t;

  vec_t vecs[8];
  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] all_outs();
    return {o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid, o_ls_rdata,
            o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_timeout};
  endfunction

  // Scoreboard consumer: every rvalid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (o_if_rvalid || o_ls_rvalid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rvalid: got if=%0b ls=%0b expected none", o_if_rvalid, o_ls_rvalid);
      end else begin
        mon_e = sb_q.pop_front();
        check("rvalid_owner", {94'd0, o_if_rvalid, o_ls_rvalid}, mon_e.owner_ls ? 96'd1 : 96'd2);
        check("rdata", mon_e.owner_ls ? o_ls_rdata : o_if_rdata, mon_e.rdata);
      end
    end
  end

  // Entered on a negedge with the arbiter idle; returns on the negedge of the rvalid cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    if (v.is_ls) begin
      i_ls_req = 1'b1; i_ls_we = v.we; i_ls_addr = v.addr; i_ls_wdata = v.wdata;
    end else begin
      i_if_req = 1'b1; i_if_addr = v.addr;
    end
    @(negedge clk);
    check("if_gnt", o_if_gnt, !v.is_ls);
    check("ls_gnt", o_ls_gnt, v.is_ls);
    check("mem_req_on_gnt", o_mem_req, 1);
    check("mem_addr", o_mem_addr, v.addr);
    check("mem_we", o_mem_we, v.is_ls && v.we);
    if (v.is_ls && v.we) check("mem_wdata", o_mem_wdata, v.wdata);
    check("busy", o_busy, 1);
    i_if_req = 1'b0;
    i_ls_req = 1'b0;
    n = (v.delay >= TO) ? TO - 1 : v.delay;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("mem_req_held", o_mem_req, 1);
      check("mem_addr_held", o_mem_addr, v.addr);
      check("gnt_single_pulse", {o_if_gnt, o_ls_gnt}, 0);
      if (v.is_ls && v.we) check("mem_wdata_held", {o_mem_we, o_mem_wdata}, {1'b1, v.wdata});
    end
    if (v.delay < TO) begin
      i_mem_ack = 1'b1;
      i_mem_rdata = v.mem_rdata;
    end
    sb_q.push_back('{v.is_ls, v.exp_rdata});
    @(negedge clk);
    i_mem_ack = 1'b0;
    check("rvalid_pulse", v.is_ls ? o_ls_rvalid : o_if_rvalid, 1);
    check("mem_req_dropped", o_mem_req, 0);
    check("busy_clear", o_busy, 0);
    check("timeout_flag", o_timeout, v.exp_to);
    $display("txn %0d: %s we=%0b addr=%h delay=%0d rdata_if=%h rdata_ls=%h timeout=%0b",
             idx, v.is_ls ? "LS" : "IF", v.we, v.addr, v.delay, o_if_rdata, o_ls_rdata, o_timeout);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t v;
    logic exp_if_wins;
    //            ls   we   addr      wdata     dly  mem_rdata exp_rdata to
    vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2,  16'hBEEF, 16'hBEEF, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 0,  16'h1111, 16'h1111, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'h0200, 16'h1234, 3,  16'h5555, 16'hBEEF, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'h0102, 16'h0000, 14, 16'h2222, 16'h2222, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 5,  16'hA5A5, 16'hA5A5, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 16'h0104, 16'h0000, 15, 16'h9999, 16'hFFFF, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 16'h0106, 16'h0000, 1,  16'h3333, 16'h3333, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 16'h0400, 16'h0000, 0,  16'h7E7E, 16'h7E7E, 1'b1};

    i_reset_n = 1'b0; i_if_req = 1'b0; i_if_addr = '0; i_ls_req = 1'b0; i_ls_we = 1'b0;
    i_ls_addr = '0; i_ls_wdata = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    i_reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Ack while idle must be ignored.
    i_mem_ack = 1'b1; i_mem_rdata = 16'hDEAD;
    @(negedge clk);
    i_mem_ack = 1'b0;
    check("idle_ack_no_req", {o_mem_req, o_busy}, 0);
    check("idle_ack_rdata", {o_if_rdata, o_ls_rdata}, {16'h3333, 16'h7E7E});
    $display("txn idle_ack: rdata_if=%h rdata_ls=%h", o_if_rdata, o_ls_rdata);

    // Reset in the middle of a fetch.
    i_if_req = 1'b1; i_if_addr = 16'h0700;
    @(negedge clk);
    check("rst_seq_gnt", o_if_gnt, 1);
    i_if_req = 1'b0;
    @(negedge clk);
    check("rst_seq_req_before", o_mem_req, 1);
    i_reset_n = 1'b0;
    #1;
    check("reset_mid_xfer_outputs", all_outs(), 0);
    @(negedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
    $display("txn reset_mid_xfer: outputs=%h", all_outs());
    v = '{1'b0, 1'b0, 16'h0702, 16'h0000, 1, 16'h4444, 16'h4444, 1'b0};
    run_vec(v, 8);

    // Contention: LS wins, requester drops after gnt, held IF granted two cycles after ack.
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 16'h0500;
    i_if_req = 1'b1; i_if_addr = 16'h0600;
    @(negedge clk);
    check("cont1_gnt", {o_if_gnt, o_ls_gnt}, 2'b01);
    check("cont1_addr", o_mem_addr, 16'h0500);
    i_ls_req = 1'b0;
    @(negedge clk);
    check("cont1_if_waits", o_if_gnt, 0);
    i_mem_ack = 1'b1; i_mem_rdata = 16'h5A5A;
    sb_q.push_back('{1'b1, 16'h5A5A});
    @(negedge clk);
    i_mem_ack = 1'b0;
    check("cont1_ls_rvalid", {o_ls_rvalid, o_mem_req, o_if_gnt}, 3'b100);
    @(negedge clk);
    check("cont1_if_gnt", {o_if_gnt, o_mem_req, o_mem_we}, 3'b110);
    check("cont1_if_addr", o_mem_addr, 16'h0600);
    i_if_req = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 16'h6B6B;
    sb_q.push_back('{1'b0, 16'h6B6B});
    @(negedge clk);
    i_mem_ack = 1'b0;
    check("cont1_if_rvalid", o_if_rvalid, 1);
    $display("txn contention1: rdata_if=%h rdata_ls=%h", o_if_rdata, o_ls_rdata);

    // Second contention right after an LS grant.
    v = '{1'b1, 1'b0, 16'h0800, 16'h0000, 0, 16'h1010, 16'h1010, 1'b0};
    run_vec(v, 9);
`ifdef MEST_PRO_ARB_ROUND_ROBIN_EN
    exp_if_wins = 1'b1;
`else
    exp_if_wins = 1'b0;
`endif
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 16'h0A00;
    i_if_req = 1'b1; i_if_addr = 16'h0900;
    @(negedge clk);
    check("cont2_gnt", {o_if_gnt, o_ls_gnt}, exp_if_wins ? 2'b10 : 2'b01);
    check("cont2_addr", o_mem_addr, exp_if_wins ? 16'h0900 : 16'h0A00);
    i_ls_req = 1'b0; i_if_req = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 16'hC0DE;
    sb_q.push_back('{!exp_if_wins, 16'hC0DE});
    @(negedge clk);
    i_mem_ack = 1'b0;
    check("cont2_rvalid", {o_if_rvalid, o_ls_rvalid}, exp_if_wins ? 2'b10 : 2'b01);
    $display("txn contention2: rdata_if=%h rdata_ls=%h", o_if_rdata, o_ls_rdata);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
